// File: rtl/ntr_cmd_pkg.sv
// Shared opcodes, default chip ID and state encoding for the NTR command stage.
package ntr_cmd_pkg;

  localparam logic [7:0] OP_LED       = 8'hFF;
  localparam logic [7:0] OP_FIFO_BYTE = 8'h22;
  localparam logic [7:0] OP_FIFO_PACK = 8'h24;
  localparam logic [7:0] OP_CHIPID    = 8'h90;
  localparam logic [7:0] OP_ID_FF     = 8'h9F;

  localparam logic [31:0] CHIP_ID_DEFAULT = 32'h807F01E0;

  // Byte slots in one packed response word.
  localparam int unsigned PACK_SLOTS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReady,
    StDone
  } ntr_state_e;

  // Number of FIFO bytes a word of this opcode may consume.
  function automatic logic [2:0] pack_limit(input logic [7:0] op);
    return (op == OP_FIFO_PACK) ? 3'(PACK_SLOTS) : 3'd1;
  endfunction

endpackage

// File: rtl/ntr_byte_packer.sv
// Accumulates up to limit_i FIFO bytes little-endian into one word; an empty FIFO ends the
// word early with the missing bytes left as zero.
module ntr_byte_packer
  import ntr_cmd_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [2:0]                limit_i,
  input  logic                      fifo_empty_i,
  input  logic [7:0]                fifo_data_i,
  output logic                      rd_en_o,
  output logic                      done_o,
  output logic                      none_o,
  output logic [8*PACK_SLOTS-1:0]   word_o
);

  logic [8*PACK_SLOTS-1:0] acc_q;
  logic [2:0]              cnt_q;

  // Pop/complete decisions and the word including this cycle's byte.
  always_comb begin
    rd_en_o = en_i && !fifo_empty_i && (cnt_q < limit_i);
    done_o  = en_i && (fifo_empty_i || ((cnt_q + 3'd1) >= limit_i));
    none_o  = en_i && fifo_empty_i && (cnt_q == 3'd0);
    word_o  = acc_q;
    if (rd_en_o) begin
      word_o[{cnt_q[1:0], 3'b000} +: 8] = fifo_data_i;
    end
  end

  // Accumulator clears whenever idle or once a word is handed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= 3'd0;
    end else if (!en_i || done_o) begin
      acc_q <= '0;
      cnt_q <= 3'd0;
    end else if (rd_en_o) begin
      acc_q <= word_o;
      cnt_q <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/ntr_word_source.sv
// Latches decoded NTR commands and prefetches registered 32-bit response words.
module ntr_word_source
  import ntr_cmd_pkg::*;
#(
  parameter int unsigned WORDS_PER_CMD = 128,
  parameter logic [31:0] CHIP_ID       = CHIP_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  input  logic [63:0] command_i,
  input  logic        word_req_i,
  input  logic        fifo_empty_i,
  input  logic [7:0]  fifo_data_i,
  output logic        fifo_rd_en_o,
  output logic [31:0] data_word_o,
  output logic        word_valid_o,
  output logic        led_o,
  output logic        late_req_o
);

  localparam int unsigned   CntW    = $clog2(WORDS_PER_CMD + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WORDS_PER_CMD - 1);

  ntr_state_e      state_q;
  logic [7:0]      op_q;
  logic [CntW-1:0] cnt_q;
  logic            cmd_q, cmd_prev_q, req_q;
  logic [31:0]     data_q;
  logic            valid_q, led_q, late_q;

  logic        cmd_rise, cmd_fall, is_fifo_op, pack_en;
  logic        pack_rd_en, pack_done, pack_none;
  logic [31:0] pack_word;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^{command_i[63:57], command_i[55:8]};

  // Edge detection on the registered decoder level; FIFO ops hand word assembly to the packer.
  always_comb begin
    cmd_rise   = cmd_q && !cmd_prev_q;
    cmd_fall   = !cmd_q && cmd_prev_q;
    is_fifo_op = (op_q == OP_FIFO_BYTE) || (op_q == OP_FIFO_PACK);
    pack_en    = (state_q == StLoad) && is_fifo_op && !cmd_fall;
  end

  ntr_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (pack_en),
    .limit_i      (pack_limit(op_q)),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .rd_en_o      (pack_rd_en),
    .done_o       (pack_done),
    .none_o       (pack_none),
    .word_o       (pack_word)
  );

  // Input sampling: cmd_valid and word_req are registered before the FSM acts on them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= 1'b0;
      cmd_prev_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      cmd_q      <= cmd_valid_i;
      cmd_prev_q <= cmd_q;
      req_q      <= word_req_i;
    end
  end

  // Command FSM with registered response word, valid, LED and late-request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 8'h00;
      cnt_q   <= '0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      led_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      if (cmd_fall) begin
        // Any partially packed bytes are dropped along with the transfer.
        state_q <= StIdle;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_rise) begin
              op_q    <= command_i[7:0];
              cnt_q   <= '0;
              state_q <= StLoad;
            end
          end
          StLoad: begin
            if (is_fifo_op) begin
              if (pack_done) begin
                // An empty FIFO on a single-byte read is reported via bit 24.
                data_q  <= (op_q == OP_FIFO_BYTE && pack_none) ? 32'h0100_0000 : pack_word;
                valid_q <= 1'b1;
                state_q <= StReady;
              end
            end else begin
              case (op_q)
                OP_LED: begin
                  led_q  <= command_i[56];
                  data_q <= 32'd1;
                end
                OP_CHIPID: data_q <= CHIP_ID;
                OP_ID_FF:  data_q <= 32'hFFFF_FFFF;
                default:   data_q <= 32'h0;
              endcase
              valid_q <= 1'b1;
              state_q <= StReady;
            end
          end
          StReady: begin
            if (req_q) begin
              cnt_q <= cnt_q + CntW'(1);
              if (cnt_q == LastIdx) begin
                data_q  <= 32'h0;
                valid_q <= 1'b1;
                state_q <= StDone;
              end else begin
                valid_q <= 1'b0;
                state_q <= StLoad;
              end
            end
          end
          StDone: begin
          end
          default: state_q <= StIdle;
        endcase
      end

      // A request against an unprepared word is flagged; setting wins over the LED clear.
      if (req_q && !valid_q) begin
        late_q <= 1'b1;
      end else if ((state_q == StLoad) && (op_q == OP_LED) && !cmd_fall) begin
        late_q <= 1'b0;
      end
    end
  end

  assign fifo_rd_en_o = pack_rd_en;
  assign data_word_o  = data_q;
  assign word_valid_o = valid_q;
  assign led_o        = led_q;
  assign late_req_o   = late_q;

endmodule

// File: tb/tb_ntr_word_source.sv
// Self-checking bench for ntr_word_source with a queue-based FIFO and response model.
module tb_ntr_word_source;

  localparam int unsigned WPC  = 4;
  localparam logic [31:0] CHIP = 32'h807F01E0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [63:0] command = 64'h0;
  logic        word_req = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic [31:0] data_word;
  logic        word_valid, led, late_req;

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int bad_rd = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic exp_led = 1'b0;

  ntr_word_source #(
    .WORDS_PER_CMD (WPC),
    .CHIP_ID       (CHIP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .command_i    (command),
    .word_req_i   (word_req),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_en_o (fifo_rd_en),
    .data_word_o  (data_word),
    .word_valid_o (word_valid),
    .led_o        (led),
    .late_req_o   (late_req)
  );

  always #5 clk = ~clk;

  task automatic fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // First-word-fall-through FIFO: pop on the edge that sees fifo_rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      if (fifo_empty || fifo_q.size() == 0) bad_rd++;
      else begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
    end
    #1;
    fifo_drive();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_drive();
  endtask

  task automatic start_cmd(input logic [7:0] op, input logic b56);
    command = 64'h0;
    command[7:0] = op;
    command[56] = b56;
    cmd_valid = 1'b1;
  endtask

  task automatic end_cmd();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic pulse_req();
    word_req = 1'b1;
    tick();
    word_req = 1'b0;
  endtask

  // Ticks until word_valid is high; n = ticks taken or -1 on timeout.
  task automatic wait_valid(input int max_ticks, output int n);
    n = -1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (word_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Reference: next word for an opcode and the number of LOAD cycles it needs.
  task automatic model_word(input logic [7:0] op, output logic [31:0] w, output int lat);
    logic [7:0] b;
    int nb;
    w = 32'h0;
    lat = 1;
    case (op)
      8'h22: begin
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          w = {24'h0, b};
        end else w = 32'h0100_0000;
      end
      8'h24: begin
        nb = 0;
        while (nb < 4 && exp_q.size() > 0) begin
          b = exp_q.pop_front();
          w = w | (32'(b) << (8 * nb));
          nb++;
        end
        lat = (nb == 4) ? 4 : nb + 1;
      end
      8'h90: w = CHIP;
      8'h9F: w = 32'hFFFF_FFFF;
      8'hFF: w = 32'd1;
      default: w = 32'h0;
    endcase
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    n_cmp++; if (data_word !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", data_word); end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", word_valid); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL rst_led: got %b want 0", led); end
    n_cmp++; if (late_req !== 1'b0) begin n_err++; $display("FAIL rst_late: got %b want 0", late_req); end
    tick();
    rst_n = 1'b1;
    tick();
    // Reset in the middle of a packed load.
    pop_cnt = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    start_cmd(8'h24, 1'b0);
    tick(); tick(); tick();
    n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL rst_mid_pops: got %0d want 1", pop_cnt); end
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL rst_mid_rd_en: got %b want 1", fifo_rd_en); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_async_rd_en: got %b want 0", fifo_rd_en); end
    n_cmp++; if (word_valid !== 1'b0 || data_word !== 32'h0) begin
      n_err++; $display("FAIL rst_async_out: got %b/%h want 0/0", word_valid, data_word); end
    cmd_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL rst_no_pop: got %0d want 1", pop_cnt); end
    rst_n = 1'b1;
    tick();
    fifo_q.delete();
    exp_q.delete();
    fifo_drive();
  endtask

  task automatic test_chipid();
    int n;
    start_cmd(8'h90, 1'b0);
    wait_valid(10, n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL chip_lat0: got %0d want 3", n); end
    n_cmp++; if (data_word !== CHIP) begin n_err++; $display("FAIL chip_w0: got %h want %h", data_word, CHIP); end
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      wait_valid(10, n);
      n_cmp++; if (n !== 2) begin n_err++; $display("FAIL chip_lat%0d: got %0d want 2", i + 1, n); end
      n_cmp++; if (data_word !== CHIP) begin n_err++; $display("FAIL chip_w%0d: got %h want %h", i + 1, data_word, CHIP); end
    end
    end_cmd();
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL chip_end_valid: got %b want 0", word_valid); end
  endtask

  task automatic test_pack();
    int n, lat;
    logic [31:0] w;
    pop_cnt = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    start_cmd(8'h24, 1'b0);
    model_word(8'h24, w, lat);
    wait_valid(12, n);
    n_cmp++; if (n !== 2 + lat) begin n_err++; $display("FAIL pack_lat0: got %0d want %0d", n, 2 + lat); end
    n_cmp++; if (data_word !== w) begin n_err++; $display("FAIL pack_w0: got %h want %h", data_word, w); end
    pulse_req();
    model_word(8'h24, w, lat);
    wait_valid(12, n);
    n_cmp++; if (n !== 1 + lat) begin n_err++; $display("FAIL pack_lat1: got %0d want %0d", n, 1 + lat); end
    n_cmp++; if (data_word !== w) begin n_err++; $display("FAIL pack_w1: got %h want %h", data_word, w); end
    end_cmd();
    n_cmp++; if (pop_cnt !== 5) begin n_err++; $display("FAIL pack_pops: got %0d want 5", pop_cnt); end
  endtask

  task automatic test_byte_empty();
    int n, lat;
    logic [31:0] w;
    pop_cnt = 0;
    start_cmd(8'h22, 1'b0);
    model_word(8'h22, w, lat);
    wait_valid(10, n);
    n_cmp++; if (n !== 2 + lat) begin n_err++; $display("FAIL byte_lat0: got %0d want %0d", n, 2 + lat); end
    n_cmp++; if (data_word !== w) begin n_err++; $display("FAIL byte_empty_w: got %h want %h", data_word, w); end
    n_cmp++; if (pop_cnt !== 0) begin n_err++; $display("FAIL byte_empty_pops: got %0d want 0", pop_cnt); end
    push(8'hA5);
    pulse_req();
    model_word(8'h22, w, lat);
    wait_valid(10, n);
    n_cmp++; if (n !== 1 + lat) begin n_err++; $display("FAIL byte_lat1: got %0d want %0d", n, 1 + lat); end
    n_cmp++; if (data_word !== w) begin n_err++; $display("FAIL byte_w1: got %h want %h", data_word, w); end
    n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL byte_pops: got %0d want 1", pop_cnt); end
    end_cmd();
  endtask

  task automatic test_late_req();
    int n;
    start_cmd(8'h9F, 1'b0);
    tick();
    word_req = 1'b1;
    tick();
    word_req = 1'b0;
    tick();
    n_cmp++; if (late_req !== 1'b1) begin n_err++; $display("FAIL late_set: got %b want 1", late_req); end
    n_cmp++; if (word_valid !== 1'b1 || data_word !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL late_word: got %b/%h want 1/ffffffff", word_valid, data_word); end
    // The early request must not count: WPC-1 more words before DONE.
    for (int i = 1; i < WPC; i++) begin
      pulse_req();
      wait_valid(10, n);
      n_cmp++; if (n !== 2 || data_word !== 32'hFFFF_FFFF) begin
        n_err++; $display("FAIL late_cnt%0d: got lat %0d word %h want 2/ffffffff", i, n, data_word); end
    end
    pulse_req();
    tick();
    n_cmp++; if (word_valid !== 1'b1 || data_word !== 32'h0) begin
      n_err++; $display("FAIL late_done: got %b/%h want 1/0", word_valid, data_word); end
    end_cmd();
  endtask

  task automatic test_led_done();
    int n;
    start_cmd(8'hFF, 1'b1);
    wait_valid(10, n);
    n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL led_on: got %b want 1", led); end
    n_cmp++; if (late_req !== 1'b0) begin n_err++; $display("FAIL led_late_clr: got %b want 0", late_req); end
    n_cmp++; if (n !== 3 || data_word !== 32'd1) begin
      n_err++; $display("FAIL led_w0: got lat %0d word %h want 3/1", n, data_word); end
    for (int i = 1; i < WPC; i++) begin
      pulse_req();
      wait_valid(10, n);
      n_cmp++; if (n !== 2 || data_word !== 32'd1) begin
        n_err++; $display("FAIL led_w%0d: got lat %0d word %h want 2/1", i, n, data_word); end
    end
    for (int i = 0; i < 2; i++) begin
      pulse_req();
      tick(); tick();
      n_cmp++; if (word_valid !== 1'b1 || data_word !== 32'h0) begin
        n_err++; $display("FAIL led_done%0d: got %b/%h want 1/0", i, word_valid, data_word); end
    end
    n_cmp++; if (late_req !== 1'b0) begin n_err++; $display("FAIL done_no_late: got %b want 0", late_req); end
    end_cmd();
    start_cmd(8'hFF, 1'b0);
    wait_valid(10, n);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL led_off: got %b want 0", led); end
    end_cmd();
  endtask

  task automatic test_fall_mid_pack();
    int n, lat;
    logic [31:0] w;
    pop_cnt = 0;
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    start_cmd(8'h24, 1'b0);
    tick(); tick(); tick();
    cmd_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL fall_valid: got %b want 0", word_valid); end
    n_cmp++; if (pop_cnt !== 2) begin n_err++; $display("FAIL fall_pops: got %0d want 2", pop_cnt); end
    tick(); tick();
    n_cmp++; if (pop_cnt !== 2 || fifo_rd_en !== 1'b0) begin
      n_err++; $display("FAIL fall_idle: got pops %0d rd_en %b want 2/0", pop_cnt, fifo_rd_en); end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    start_cmd(8'h24, 1'b0);
    model_word(8'h24, w, lat);
    wait_valid(12, n);
    n_cmp++; if (n !== 2 + lat || data_word !== w) begin
      n_err++; $display("FAIL fall_next: got lat %0d word %h want %0d/%h", n, data_word, 2 + lat, w); end
    end_cmd();
  endtask

  task automatic test_random();
    logic [7:0] ops[8] = '{8'h22, 8'h24, 8'h24, 8'h90, 8'h9F, 8'hFF, 8'h00, 8'h5A};
    logic [7:0] op;
    logic b56;
    logic [31:0] w;
    int n, lat, k;
    for (int it = 0; it < 10; it++) begin
      op = ops[$urandom_range(0, 7)];
      b56 = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 6);
      for (int j = 0; j < k; j++) push(8'($urandom_range(0, 255)));
      start_cmd(op, b56);
      if (op == 8'hFF) exp_led = b56;
      model_word(op, w, lat);
      wait_valid(12, n);
      n_cmp++; if (n !== 2 + lat || data_word !== w) begin
        n_err++; $display("FAIL rnd%0d_op%h_w0: got lat %0d word %h want %0d/%h", it, op, n, data_word, 2 + lat, w); end
      n_cmp++; if (led !== exp_led) begin n_err++; $display("FAIL rnd%0d_led: got %b want %b", it, led, exp_led); end
      k = $urandom_range(0, WPC - 1);
      for (int r = 1; r <= k; r++) begin
        if ($urandom_range(0, 1) == 1) push(8'($urandom_range(0, 255)));
        pulse_req();
        model_word(op, w, lat);
        wait_valid(12, n);
        n_cmp++; if (n !== 1 + lat || data_word !== w) begin
          n_err++; $display("FAIL rnd%0d_op%h_w%0d: got lat %0d word %h want %0d/%h", it, op, r, n, data_word, 1 + lat, w); end
      end
      end_cmd();
    end
  endtask

  initial begin
    test_reset();
    test_chipid();
    test_pack();
    test_byte_empty();
    test_late_req();
    test_led_done();
    test_fall_mid_pack();
    exp_led = 1'b0;
    test_random();
    n_cmp++; if (bad_rd !== 0) begin n_err++; $display("FAIL rd_while_empty: got %0d want 0", bad_rd); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
